// File: rtl/spi_pixel_pkg.sv
// spi_pixel_pkg
//   Shared definitions for the SPI pixel writer: command opcodes, the 32-bit
//   frame layout, and the fill FSM state encoding.
//   Frame layout, MSB first on the wire:
//     [31:24] opcode, [23:18] x, [17:12] y, [11:0] colour (RGB444)
package spi_pixel_pkg;

    localparam int unsigned FRAME_BITS     = 32;
    localparam int unsigned CMD_DIM_BITS   = 6;
    localparam int unsigned CMD_COLOR_BITS = 12;

    localparam logic [7:0] OP_WRITE_PIXEL = 8'h01;
    localparam logic [7:0] OP_FILL        = 8'h02;

    typedef struct packed {
        logic [7:0]                op;
        logic [CMD_DIM_BITS-1:0]   x;
        logic [CMD_DIM_BITS-1:0]   y;
        logic [CMD_COLOR_BITS-1:0] color;
    } pixel_cmd_t;

    typedef enum logic {
        IDLE,
        FILL
    } writer_state_t;

    // True for the opcodes that produce a command; anything else is dropped.
    function automatic logic is_cmd_op(input logic [7:0] op);
        return (op == OP_WRITE_PIXEL) || (op == OP_FILL);
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// spi_frame_rx
//   Oversampling SPI mode-0 slave receiver. Synchronizes sck/cs_n/mosi into
//   the i_clk domain, detects sck rising edges and shifts mosi MSB first.
//   Emits a one-cycle o_frame_valid pulse each time 32 bits have been
//   collected inside one cs_n window; o_frame_data holds the frame in that
//   cycle. Any cs_n edge zeroes the bit counter, discarding a partial frame.
// Ports:
//   i_clk, i_reset_n       system clock, synchronous active-low reset
//   i_sck, i_cs_n, i_mosi  asynchronous SPI pins
//   o_frame_valid          one-cycle pulse, frame complete
//   o_frame_data           received 32-bit frame
module spi_frame_rx
    import spi_pixel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_sck,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_frame_valid,
    output logic [FRAME_BITS-1:0] o_frame_data
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;
    logic [4:0]             r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic                   r_frame_valid;

    logic w_sck;
    logic w_cs_n;
    logic w_mosi;
    logic w_sck_rise;
    logic w_cs_edge;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Edges are taken between the last synchronized sample and the one
    // before it; mosi passes through the same depth so it stays aligned.
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_cs_edge  = w_cs_n ^ r_cs_prev;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sck_sync    <= '0;
            r_cs_sync     <= '1;
            r_mosi_sync   <= '0;
            r_sck_prev    <= 1'b0;
            r_cs_prev     <= 1'b1;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_prev    <= w_sck;
            r_cs_prev     <= w_cs_n;
            r_frame_valid <= 1'b0;
            if (w_cs_edge) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise && !w_cs_n) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi};
                if (r_bit_cnt == 5'd31) begin
                    r_bit_cnt     <= '0;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    assign o_frame_valid = r_frame_valid;
    assign o_frame_data  = r_shift;

endmodule

// File: rtl/spi_pixel_writer.sv
// spi_pixel_writer
//   Decodes 32-bit SPI command frames into pixel-memory write strobes.
//   WRITE_PIXEL writes one pixel; FILL sweeps the whole framebuffer (x inner,
//   y outer) with one colour. A one-entry pending register buffers a command
//   that arrives while a fill runs; a command arriving while it is full is
//   dropped and sets the sticky overflow flag.
// Ports:
//   clk_in, reset_n        system clock, synchronous active-low reset
//   sck, cs_n, mosi        asynchronous SPI mode-0 slave pins
//   write_en               one-cycle pixel write strobe
//   write_x, write_y       pixel coordinates (held when write_en is low)
//   write_color            RGB444 colour (held when write_en is low)
//   busy                   fill running or a command pending
//   overflow               sticky dropped-command flag
module spi_pixel_writer
    import spi_pixel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIM_BITS    = 6,
    parameter int unsigned COLOR_BITS  = 12
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  write_en,
    output logic [DIM_BITS-1:0]   write_x,
    output logic [DIM_BITS-1:0]   write_y,
    output logic [COLOR_BITS-1:0] write_color,
    output logic                  busy,
    output logic                  overflow
);

    logic                  w_frame_valid;
    logic [FRAME_BITS-1:0] w_frame_data;
    pixel_cmd_t            w_cmd;
    logic                  w_cmd_ok;

    writer_state_t         r_state;
    writer_state_t         w_state_next;
    pixel_cmd_t            r_pend;
    logic                  r_pend_valid;
    logic                  r_overflow;
    logic                  w_pop;

    logic                  r_write_en;
    logic [DIM_BITS-1:0]   r_write_x;
    logic [DIM_BITS-1:0]   r_write_y;
    logic [COLOR_BITS-1:0] r_write_color;
    logic                  w_we_next;
    logic [DIM_BITS-1:0]   w_x_next;
    logic [DIM_BITS-1:0]   w_y_next;
    logic [COLOR_BITS-1:0] w_color_next;

    spi_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .i_clk         (clk_in),
        .i_reset_n     (reset_n),
        .i_sck         (sck),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_frame_valid (w_frame_valid),
        .o_frame_data  (w_frame_data)
    );

    assign w_cmd    = pixel_cmd_t'(w_frame_data);
    assign w_cmd_ok = w_frame_valid && is_cmd_op(w_cmd.op);

    // Output registers double as the fill sweep counters: during FILL the
    // strobe currently on write_x/write_y is the one just issued.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_we_next    = 1'b0;
        w_x_next     = r_write_x;
        w_y_next     = r_write_y;
        w_color_next = r_write_color;
        case (r_state)
            IDLE: begin
                if (r_pend_valid) begin
                    w_pop        = 1'b1;
                    w_we_next    = 1'b1;
                    w_color_next = COLOR_BITS'(r_pend.color);
                    if (r_pend.op == OP_FILL) begin
                        w_state_next = FILL;
                        w_x_next     = '0;
                        w_y_next     = '0;
                    end else begin
                        w_x_next = DIM_BITS'(r_pend.x);
                        w_y_next = DIM_BITS'(r_pend.y);
                    end
                end
            end
            FILL: begin
                if ((r_write_x == '1) && (r_write_y == '1)) begin
                    w_state_next = IDLE;
                end else begin
                    w_we_next = 1'b1;
                    if (r_write_x == '1) begin
                        w_x_next = '0;
                        w_y_next = r_write_y + DIM_BITS'(1);
                    end else begin
                        w_x_next = r_write_x + DIM_BITS'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_write_en    <= 1'b0;
            r_write_x     <= '0;
            r_write_y     <= '0;
            r_write_color <= '0;
        end else begin
            r_state       <= w_state_next;
            r_write_en    <= w_we_next;
            r_write_x     <= w_x_next;
            r_write_y     <= w_y_next;
            r_write_color <= w_color_next;
        end
    end

    // The pop is evaluated before the load, so an idle writer can accept a
    // new command in the same cycle it drains the slot.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_cmd_ok) begin
            if (r_pend_valid && !w_pop) begin
                r_overflow <= 1'b1;
            end else begin
                r_pend       <= w_cmd;
                r_pend_valid <= 1'b1;
            end
        end else if (w_pop) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign write_en    = r_write_en;
    assign write_x     = r_write_x;
    assign write_y     = r_write_y;
    assign write_color = r_write_color;
    assign busy        = (r_state == FILL) || r_pend_valid;
    assign overflow    = r_overflow;

endmodule
